// File: rtl/gpr_ctrl_pkg.sv
// Shared constants, types and helpers for the GPR write-back controller.
package gpr_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NUM_DEF  = 32;
    localparam int REG_AW   = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Successor of a round-robin index, wrapping modulo n.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the
// granted requester when the caller reports a transfer.
module rr_arbiter
    import gpr_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] rank [N];
    logic [N-1:0]  lower [N];
    logic [PW-1:0] nxt_acc [N+1];

    assign nxt_acc[0] = '0;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            // Distance from the pointer; rank 0 is the highest priority.
            assign rank[gi] = PW'((gi + N - int'(ptr)) % N);
            for (gj = 0; gj < N; gj++) begin : g_cmp
                assign lower[gi][gj] = req[gj] && (rank[gj] < rank[gi]);
            end
            assign gnt[gi] = req[gi] && !(|lower[gi]);
            assign nxt_acc[gi+1] = nxt_acc[gi] | (gnt[gi] ? PW'(rr_next(gi, N)) : '0);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= nxt_acc[N];
        end
    end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// Write-back controller: round-robin share of the register-file write port plus
// a busy scoreboard for RAW/WAW detection. Optional macro GPR_WB_FORWARD_EN.
module gpr_wb_ctrl
    import gpr_ctrl_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NUM  = NUM_DEF,
    parameter  int NREQ = 3,
    localparam int AW   = $clog2(NUM)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rd,
    output logic               issue_ready,
    input  logic [AW-1:0]      rs1,
    input  logic [AW-1:0]      rs2,
    output logic               hazard_rs1,
    output logic               hazard_rs2,
    input  logic               flush,
    input  logic [NREQ-1:0]    wb_valid,
    input  logic [NREQ*AW-1:0] wb_rd,
    input  logic [NREQ*XLEN-1:0] wb_data,
    output logic [NREQ-1:0]    wb_ready,
`ifdef GPR_WB_FORWARD_EN
    output logic               fwd_hit1,
    output logic               fwd_hit2,
    output logic [XLEN-1:0]    fwd_data,
`endif
    output logic [AW-1:0]      addr_w,
    output logic [XLEN-1:0]    data_w
);

    logic [NUM-1:0]  busy;
    logic [NUM-1:0]  busy_set;
    logic [NUM-1:0]  busy_clr;
    logic            transfer;
    logic            issue_fire;
    logic [AW-1:0]   rd_acc   [NREQ+1];
    logic [XLEN-1:0] data_acc [NREQ+1];

    rr_arbiter #(.N(NREQ)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (wb_valid),
        .advance (transfer),
        .gnt     (wb_ready)
    );

    assign transfer    = |(wb_valid & wb_ready);
    assign issue_ready = !busy[issue_rd];
    assign issue_fire  = issue_valid && issue_ready;

    assign rd_acc[0]   = '0;
    assign data_acc[0] = '0;

    genvar gi;
    generate
        // Grant is one-hot, so an OR-chain acts as the selection mux.
        for (gi = 0; gi < NREQ; gi++) begin : g_sel
            assign rd_acc[gi+1]   = rd_acc[gi]   | ({AW{wb_ready[gi]}}   & wb_rd[gi*AW +: AW]);
            assign data_acc[gi+1] = data_acc[gi] | ({XLEN{wb_ready[gi]}} & wb_data[gi*XLEN +: XLEN]);
        end
        for (gi = 0; gi < NUM; gi++) begin : g_sb
            if (gi == 0) begin : g_x0
                assign busy_set[gi] = 1'b0;
                assign busy_clr[gi] = 1'b0;
            end else begin : g_xn
                assign busy_set[gi] = issue_fire && (issue_rd == AW'(gi));
                assign busy_clr[gi] = transfer && (rd_acc[NREQ] == AW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_w <= '0;
            data_w <= '0;
        end else if (transfer) begin
            addr_w <= rd_acc[NREQ];
            data_w <= data_acc[NREQ];
        end else begin
            addr_w <= '0;
        end
    end

`ifdef GPR_WB_FORWARD_EN
    assign fwd_hit1   = (addr_w == rs1) && (rs1 != '0);
    assign fwd_hit2   = (addr_w == rs2) && (rs2 != '0);
    assign fwd_data   = data_w;
    assign hazard_rs1 = busy[rs1];
    assign hazard_rs2 = busy[rs2];
`else
    // The addr_w term covers the cycle between the busy clear and the file write.
    assign hazard_rs1 = busy[rs1] | ((addr_w == rs1) && (rs1 != '0));
    assign hazard_rs2 = busy[rs2] | ((addr_w == rs2) && (rs2 != '0));
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl: arbitration order, output latency,
// scoreboard hazards, x0 writes, flush and asynchronous reset.
module tb_gpr_wb_ctrl;
    import gpr_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int NUM  = 32;
    localparam int NREQ = 3;
    localparam int AW   = 5;
`ifdef GPR_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 issue_valid;
    reg_addr_t            issue_rd;
    logic                 issue_ready;
    reg_addr_t            rs1, rs2;
    logic                 hazard_rs1, hazard_rs2;
    logic                 flush;
    logic [NREQ-1:0]      wb_valid;
    logic [NREQ*AW-1:0]   wb_rd;
    logic [NREQ*XLEN-1:0] wb_data;
    logic [NREQ-1:0]      wb_ready;
    logic [AW-1:0]        addr_w;
    logic [XLEN-1:0]      data_w;
`ifdef GPR_WB_FORWARD_EN
    logic                 fwd_hit1, fwd_hit2;
    logic [XLEN-1:0]      fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    gpr_wb_ctrl #(.XLEN(XLEN), .NUM(NUM), .NREQ(NREQ)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard_rs1  (hazard_rs1),
        .hazard_rs2  (hazard_rs2),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
`ifdef GPR_WB_FORWARD_EN
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data    (fwd_data),
`endif
        .addr_w      (addr_w),
        .data_w      (data_w)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic set_wb(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        wb_rd[i*AW +: AW]       = rd;
        wb_data[i*XLEN +: XLEN] = data;
    endtask

    int exp_g [4] = '{1, 2, 4, 1};
    int exp_a [4] = '{1, 2, 3, 1};

    initial begin
        reset_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        flush = 1'b0; wb_valid = '0; wb_rd = '0; wb_data = '0;

        // Reset and idle
        repeat (2) @(negedge clock);
        check_eq("rst_addr_w", 64'(addr_w), 64'd0);
        check_eq("rst_data_w", 64'(data_w), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        rs1 = 5'd5; rs2 = 5'd9;
        #1;
        check_eq("idle_haz1", 64'(hazard_rs1), 64'd0);
        check_eq("idle_haz2", 64'(hazard_rs2), 64'd0);
        check_eq("idle_addr_w", 64'(addr_w), 64'd0);
        for (int r = 0; r < NUM; r += 5) begin
            issue_rd = 5'(r);
            #0.1;
            check_eq($sformatf("idle_ready_rd%0d", r), 64'(issue_ready), 64'd1);
        end

        // RAW on x5 and the one-cycle addr_w window
        @(negedge clock);
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 check_eq("issue5_ready", 64'(issue_ready), 64'd1);
        @(negedge clock);
        issue_valid = 1'b0; rs1 = 5'd5;
        set_wb(1, 5'd5, 32'hDEADBEEF); wb_valid = 3'b010;
        #1;
        check_eq("raw_haz1_busy", 64'(hazard_rs1), 64'd1);
        check_eq("lsu_grant", 64'(wb_ready), 64'b010);
        @(negedge clock);
        wb_valid = '0;
        #1;
        check_eq("lsu_addr_w", 64'(addr_w), 64'd5);
        check_eq("lsu_data_w", 64'(data_w), 64'hDEADBEEF);
        check_eq("raw_haz1_window", 64'(hazard_rs1), FWD ? 64'd0 : 64'd1);
        @(negedge clock);
        #1;
        check_eq("raw_haz1_clear", 64'(hazard_rs1), 64'd0);
        check_eq("idle_addr_w2", 64'(addr_w), 64'd0);
        check_eq("data_w_hold", 64'(data_w), 64'hDEADBEEF);

        // Fresh reset so the pointer starts at requester 0
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        set_wb(0, 5'd1, 32'hA0); set_wb(1, 5'd2, 32'hA1); set_wb(2, 5'd3, 32'hA2);
        wb_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", k), 64'(wb_ready), 64'(exp_g[k]));
            if (k > 0) check_eq($sformatf("rr_addr%0d", k - 1), 64'(addr_w), 64'(exp_a[k-1]));
            @(negedge clock);
        end
        #1;
        check_eq("rr_addr3", 64'(addr_w), 64'(exp_a[3]));
        check_eq("rr_data3", 64'(data_w), 64'hA0);
        wb_valid = '0;

        // WAW on x7 (pointer now at 1, only requester 2 valid)
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clock);
        #1 check_eq("waw_stall", 64'(issue_ready), 64'd0);
        set_wb(2, 5'd7, 32'h77); wb_valid = 3'b100;
        #1 check_eq("waw_grant", 64'(wb_ready), 64'b100);
        @(negedge clock);
        #1;
        check_eq("waw_release", 64'(issue_ready), 64'd1);
        check_eq("waw_addr_w", 64'(addr_w), 64'd7);
        check_eq("waw_data_w", 64'(data_w), 64'h77);
        issue_valid = 1'b0; wb_valid = '0;

        // Write-back to x0 (pointer now at 0)
        @(negedge clock);
        set_wb(0, 5'd0, 32'h1234); wb_valid = 3'b001; rs1 = 5'd0; issue_rd = 5'd0;
        #1;
        check_eq("x0_grant", 64'(wb_ready), 64'b001);
        check_eq("x0_ready", 64'(issue_ready), 64'd1);
        @(negedge clock);
        wb_valid = '0;
        #1;
        check_eq("x0_addr_w", 64'(addr_w), 64'd0);
        check_eq("x0_data_w", 64'(data_w), 64'h1234);
        check_eq("x0_haz1", 64'(hazard_rs1), 64'd0);
        rs1 = 5'd7;
        #1 check_eq("x0_sb_x7", 64'(hazard_rs1), 64'd0);

        // Flush with x3, x9 busy and a simultaneous issue of x4 (pointer at 1)
        @(negedge clock);
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clock);
        issue_rd = 5'd9;
        @(negedge clock);
        issue_valid = 1'b0; rs1 = 5'd3; rs2 = 5'd9;
        #1;
        check_eq("pre_flush_haz3", 64'(hazard_rs1), 64'd1);
        check_eq("pre_flush_haz9", 64'(hazard_rs2), 64'd1);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
        set_wb(1, 5'd9, 32'h99); wb_valid = 3'b010;
        #1 check_eq("flush_grant", 64'(wb_ready), 64'b010);
        @(negedge clock);
        flush = 1'b0; issue_valid = 1'b0; wb_valid = '0;
        rs1 = 5'd3; rs2 = 5'd4; issue_rd = 5'd9;
        #1;
        check_eq("flush_haz3", 64'(hazard_rs1), 64'd0);
        check_eq("flush_haz4", 64'(hazard_rs2), 64'd0);
        check_eq("flush_ready9", 64'(issue_ready), 64'd1);
        check_eq("flush_addr_w", 64'(addr_w), 64'd9);
        check_eq("flush_data_w", 64'(data_w), 64'h99);
        rs1 = 5'd9;
        #0.5 check_eq("flush_haz9_window", 64'(hazard_rs1), FWD ? 64'd0 : 64'd1);

        // Asynchronous reset mid-cycle while addr_w = 9
        reset_n = 1'b0;
        #0.5;
        check_eq("async_rst_addr_w", 64'(addr_w), 64'd0);
        check_eq("async_rst_data_w", 64'(data_w), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
- Write-back controller for the 2R1W general-purpose register file.
- Shares the single write port (addr_w/data_w) between NREQ write-back requesters (ALU, LSU, MDU, ...) using round-robin arbitration.
- Keeps a per-register busy scoreboard so issue logic sees RAW hazards and is stalled on WAW.
- Sits between the execute units and the register file, next to the issue stage.

Parameters:
- XLEN, 32, data width.
- NUM, 32, number of architectural registers; AW = $clog2(NUM).
- NREQ, 3, number of write-back requesters (2..8).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue stage is dispatching an instruction that writes issue_rd.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ready  out  1  issue may proceed; low on a WAW conflict.
- rs1, rs2  in  AW  source registers of the instruction in issue.
- hazard_rs1, hazard_rs2  out  1  source register value is not yet architecturally valid.
- flush  in  1  pipeline flush; clears the scoreboard.
- wb_valid  in  NREQ  per-requester write-back request.
- wb_rd  in  NREQ*AW  packed destination registers, requester i at bits [i*AW +: AW].
- wb_data  in  NREQ*XLEN  packed write data.
- wb_ready  out  NREQ  one-hot grant; combinational.
- addr_w  out  AW  register-file write address, registered; 0 means no write.
- data_w  out  XLEN  register-file write data, registered.

Behaviour:
- Reset (async, reset_n=0):
  - busy = all zeros, addr_w = 0, data_w = 0.
  - RR pointer = 0, so requester 0 has highest priority first.
- Arbitration:
  - Each cycle, at most one wb_ready bit is high: the first valid requester at or after the pointer, wrapping modulo NREQ.
  - wb_ready[i] is never high unless wb_valid[i] is high.
  - A transfer occurs when wb_valid[i] & wb_ready[i]. The pointer then moves to i+1 mod NREQ.
  - With no transfer, the pointer holds.
- Output stage and latency:
  - On a transfer in cycle t, addr_w <= wb_rd[i] and data_w <= wb_data[i] at the end of t.
  - The register file writes at the end of t+1.
  - With no transfer, addr_w <= 0 and data_w holds its previous value.
  - Sustained throughput: one write per cycle.
- Requesters hold wb_valid, wb_rd and wb_data stable until granted; the block does not check this.
- x0 handling: a transfer with wb_rd=0 is accepted, addr_w becomes 0, nothing is written and the scoreboard is unchanged.
- Scoreboard:
  - busy[r] is set at the edge where issue_valid & issue_ready & issue_rd != 0.
  - busy[r] is cleared at the transfer edge for wb_rd = r.
  - busy[0] is always 0.
- issue_ready = !busy[issue_rd]. Because of this, a set and a clear of the same register never coincide.
- Different registers may be set and cleared in the same cycle; both take effect.
- Hazard, for k = 1, 2:
  - hazard_rsk = busy[rsk] | (addr_w == rsk & rsk != 0).
  - This covers the one-cycle window between the busy clear and the actual file write.
- flush:
  - Clears all busy bits at the next edge.
  - A flush in the same cycle as an issue wins, so that register ends up not busy.
  - Does not affect the output stage, the pointer, or grants in progress. Late write-backs still write.
- Write-back to a register that is not busy: the write is performed and no error is raised.
- Reset mid-transfer: the output register clears immediately and asynchronously, so addr_w = 0 and no spurious write reaches the file.

Optional Feature:
- Macro: GPR_WB_FORWARD_EN.
- Defined:
  - Adds outputs fwd_hit1 and fwd_hit2 (1 bit each): fwd_hitk = (addr_w == rsk & rsk != 0).
  - Adds output fwd_data (XLEN), equal to data_w.
  - hazard_rsk drops the addr_w term and becomes busy[rsk] only.
  - The issue stage forwards fwd_data instead of stalling.
- Undefined: the extra ports are absent and hazard behaves as specified above.

Decomposition:
- Package gpr_ctrl_pkg:
  - Constants XLEN_DEF=32, NUM_DEF=32, REG_AW=5.
  - Typedef reg_addr_t (AW bits).
  - Function rr_next(ptr, n).
- Sub-module rr_arbiter (parameter N):
  - Inputs: clock, reset_n, req, advance.
  - Output: one-hot gnt.
  - Owns the pointer.
- The scoreboard and output stage stay in gpr_wb_ctrl.

Test Plan:
- Reset then idle: addr_w=0, all hazards 0, issue_ready=1 for all rd.
- Issue rd=5, then rs1=5: hazard_rs1=1. Grant LSU wb_rd=5, data=0xDEADBEEF:
  - Next cycle addr_w=5, data_w=0xDEADBEEF, hazard_rs1 still 1 via the addr_w term.
  - Following cycle hazard_rs1=0.
- All three requesters valid continuously with rd 1, 2, 3:
  - Grants go 0, 1, 2, 0, ...
  - addr_w sequence 1, 2, 3, 1.
- WAW: busy[7] set, issue_rd=7 → issue_ready=0. Grant rd=7 → issue_ready=1 in the following cycle.
- Write-back to x0 with data 0x1234: wb_ready=1, addr_w stays 0, scoreboard unchanged.
- flush with busy {3,9} and a simultaneous issue of rd=4:
  - Afterwards all busy bits are 0.
  - A pending wb_rd=9 is still written (addr_w=9).
  - Assert reset_n=0 while addr_w=9: addr_w goes to 0 immediately.
